pipelined_functional_unit: RTL and testbench
============================================

Name: pipelined_functional_unit

Overview:
- Parametrised, pipelined successor to the combinational functional unit.
- Same operation set: ALU ops selected by INST[3:0]; multiply-add Z = A*B + C selected by INST[4].
- Generalised data width and fixed configurable latency; valid/ready handshake on input and output; full backpressure; registered flags for every op.
- Sits between the operand-fetch/register-read stage and writeback; one op accepted per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- LAT, 3, cycles from input acceptance to OUT_VALID (>=2); identical for all ops, so results stay in order.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B, or shift amount.
- C  input  WIDTH  addend for MADD.
- INST  input  5  [4]=1 selects MADD; otherwise [3:0] is the ALU opcode.
- CI  input  1  carry-in for ADC.
- IN_VALID  input  1  operands/INST valid this cycle.
- IN_READY  output  1  unit can accept an op this cycle.
- OUT_VALID  output  1  Z/FLAGS hold a valid result.
- OUT_READY  input  1  consumer accepts the result.
- Z  output  WIDTH  result.
- FLAGS  output  4  {N, Zf, Cy, V}.

Behaviour:
- Handshake:
  - Op accepted when IN_VALID && IN_READY; result delivered when OUT_VALID && OUT_READY.
  - Pipeline is LAT registered stages (valid bit + payload each); the last stage drives Z/FLAGS/OUT_VALID.
- Stall:
  - stall = OUT_VALID && !OUT_READY. When stalled, every stage holds.
  - IN_READY = !stall. This is a combinational path from OUT_READY and is documented as such.
  - When not stalled, all stages advance. Empty stages are valid=0 (bubbles).
  - Bubbles are not compressed. Throughput is 1 op/cycle with OUT_READY held high.
- Latency:
  - An op accepted in cycle t appears with OUT_VALID=1 in cycle t+LAT, provided no stall occurs in between.
  - Each stall cycle adds one cycle.
- Ordering: strict FIFO order; no op is dropped or duplicated under any OUT_READY pattern.
- Output stability: while OUT_VALID && !OUT_READY, Z and FLAGS hold stable.
- ALU ops (INST[4]=0), INST[3:0]:
  - 0 ADD: A+B.
  - 1 ADC: A+B+CI.
  - 2 SUB: A-B (computed as A+~B+1).
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 NOT A.
  - 7 PASS A.
  - 8 SLL: A << B[log2(WIDTH)-1:0].
  - 9 SRL.
  - 10 SRA.
  - 11-15 reserved: Z=0, FLAGS=4'b0100.
- MADD (INST[4]=1; INST[3:0] ignored):
  - Z = low WIDTH bits of unsigned A*B + C.
  - Multiplier may be split across stages; only the end-to-end latency LAT is fixed.
- Flags:
  - N = Z[WIDTH-1]; Zf = (Z==0).
  - Cy = carry-out of the WIDTH-bit adder for ADD/ADC/SUB; for SUB, Cy=1 means no borrow (A>=B unsigned).
  - V = signed overflow for ADD/ADC/SUB.
  - Cy=V=0 for logic, shift and MADD ops.
- Reset:
  - RST_N low forces all stage valid bits, OUT_VALID, Z and FLAGS to 0 immediately.
  - In-flight ops are discarded.
  - IN_READY=1 while in reset.
  - First acceptance is possible on the first rising edge after release.
- Simultaneous events:
  - An input accepted in the same cycle a result is consumed is legal and required for full throughput.
  - Input while stalled is not accepted; the producer must hold its operands.

Test Plan:
- Reset release, WIDTH=32, LAT=3, OUT_READY=1: ADD A=5, B=7 at cycle 0 -> cycle 3 OUT_VALID=1, Z=12, FLAGS=0000.
- Flag checks:
  - ADD A=0x7FFFFFFF, B=1 -> Z=0x80000000, FLAGS=1001.
  - SUB A=3, B=3 -> Z=0, FLAGS=0110.
  - ADC A=0xFFFFFFFF, B=0, CI=1 -> Z=0, FLAGS=0110.
- MADD A=3, B=4, C=5 -> Z=17. Then A=0x10000, B=0x10000, C=1 -> Z=1 (wrap), FLAGS=0000.
- Back-to-back ops at 1/cycle with OUT_READY=0 for 4 cycles mid-stream:
  - IN_READY drops once the last stage fills.
  - Z holds during the stall.
  - All results emerge in order, none lost.
- Shifts:
  - SRA A=0x80000000, B=4 -> Z=0xF8000000, N=1.
  - SLL B=33 uses B[4:0]=1.
  - Reserved opcode 12 -> Z=0, FLAGS=0100.
- Assert RST_N low with 3 ops in flight -> OUT_VALID=0 immediately. After release no stale result appears; a new op completes in LAT cycles.

Source files
------------

// File: rtl/pipelined_functional_unit_if.sv
// Operand/result handshake bundle for pipelined_functional_unit.
// The producer and consumer sides both live on the master modport; the unit is the slave.
interface pipelined_functional_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [4:0]       INST;
  logic             CI;
  logic             IN_VALID;
  logic             IN_READY;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] Z;
  logic [3:0]       FLAGS;

  modport master (
    output A, B, C, INST, CI, IN_VALID, OUT_READY,
    input  IN_READY, OUT_VALID, Z, FLAGS
  );

  modport slave (
    input  A, B, C, INST, CI, IN_VALID, OUT_READY,
    output IN_READY, OUT_VALID, Z, FLAGS
  );
endinterface

// File: rtl/pipelined_functional_unit.sv
// Pipelined ALU / multiply-add unit with fixed latency LAT and valid/ready backpressure.
// Stage 1 holds ALU result plus partial MADD product; stage 2 finishes MADD and flags; the rest delay.
module pipelined_functional_unit #(
  parameter int WIDTH = 32,
  parameter int LAT   = 3
) (
  input logic CLK,
  input logic RST_N,
  pipelined_functional_unit_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  logic             w_stall;
  logic             w_accept;
  logic [3:0]       w_op;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_b_op;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_arith;
  logic             w_ovf;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_fin_z;
  logic [3:0]       w_fin_flags;

  logic [LAT-1:0]   r_valid;
  logic [WIDTH-1:0] r_s1_alu;
  logic [WIDTH-1:0] r_s1_prod;
  logic [WIDTH-1:0] r_s1_c;
  logic             r_s1_madd;
  logic             r_s1_cy;
  logic             r_s1_v;
  logic [WIDTH-1:0] r_z     [1:LAT-1];
  logic [3:0]       r_flags [1:LAT-1];

  // IN_READY is combinational from OUT_READY through this stall term.
  assign w_stall  = r_valid[LAT-1] && !bus.OUT_READY;
  assign w_accept = bus.IN_VALID && !w_stall;

  assign w_op    = bus.INST[3:0];
  assign w_sh    = bus.B[SHW-1:0];
  assign w_arith = !bus.INST[4] && (w_op <= 4'd2);

  always_comb begin
    w_b_op = bus.B;
    w_cin  = 1'b0;
    case (w_op)
      4'd1: w_cin = bus.CI;
      4'd2: begin
        w_b_op = ~bus.B;
        w_cin  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_sum  = {1'b0, bus.A} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf  = (bus.A[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
  assign w_prod = bus.A * bus.B;

  always_comb begin
    w_alu = '0;
    case (w_op)
      4'd0, 4'd1, 4'd2: w_alu = w_sum[WIDTH-1:0];
      4'd3:  w_alu = bus.A & bus.B;
      4'd4:  w_alu = bus.A | bus.B;
      4'd5:  w_alu = bus.A ^ bus.B;
      4'd6:  w_alu = ~bus.A;
      4'd7:  w_alu = bus.A;
      4'd8:  w_alu = bus.A << w_sh;
      4'd9:  w_alu = bus.A >> w_sh;
      4'd10: w_alu = WIDTH'($signed(bus.A) >>> w_sh);
      default: w_alu = '0;
    endcase
  end

  // Reserved opcodes yield Z=0 with Cy=V=0, so their 4'b0100 falls out of the generic flag rule.
  assign w_fin_z     = r_s1_madd ? (r_s1_prod + r_s1_c) : r_s1_alu;
  assign w_fin_flags = {w_fin_z[WIDTH-1], (w_fin_z == '0), r_s1_cy, r_s1_v};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid   <= '0;
      r_s1_alu  <= '0;
      r_s1_prod <= '0;
      r_s1_c    <= '0;
      r_s1_madd <= 1'b0;
      r_s1_cy   <= 1'b0;
      r_s1_v    <= 1'b0;
      for (int i = 1; i < LAT; i++) begin
        r_z[i]     <= '0;
        r_flags[i] <= '0;
      end
    end else if (!w_stall) begin
      r_valid[0] <= w_accept;
      r_s1_alu   <= w_alu;
      r_s1_prod  <= w_prod;
      r_s1_c     <= bus.C;
      r_s1_madd  <= bus.INST[4];
      r_s1_cy    <= w_arith && w_sum[WIDTH];
      r_s1_v     <= w_arith && w_ovf;

      r_valid[1] <= r_valid[0];
      r_z[1]     <= w_fin_z;
      r_flags[1] <= w_fin_flags;

      for (int i = 2; i < LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_z[i]     <= r_z[i-1];
        r_flags[i] <= r_flags[i-1];
      end
    end
  end

  assign bus.IN_READY  = !w_stall;
  assign bus.OUT_VALID = r_valid[LAT-1];
  assign bus.Z         = r_z[LAT-1];
  assign bus.FLAGS     = r_flags[LAT-1];
endmodule

// File: tb/tb_pipelined_functional_unit.sv
// Bench for pipelined_functional_unit: directed plan vectors, stall/ordering, reset flush,
// and randomized traffic scored against an arithmetic reference model.
module tb_pipelined_functional_unit;
  localparam int WIDTH = 32;
  localparam int LAT   = 3;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_res    = 0;

  logic [35:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_z     = '0;
  logic [3:0]  prev_flags = '0;

  pipelined_functional_unit_if #(.WIDTH(WIDTH)) ifc();

  pipelined_functional_unit #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=still_running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {N, Zf, Cy, V, Z} from plain wide arithmetic.
  function automatic logic [35:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [4:0] inst,
                                         input logic ci);
    longint unsigned ua, ub, uc, us;
    longint sa, sb, ss, cin;
    logic [31:0] z;
    logic cy, v;
    int sh;
    ua = a; ub = b; uc = c;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    cin = (inst[3:0] == 4'd1 && ci) ? 1 : 0;
    z = '0; cy = 1'b0; v = 1'b0;
    if (inst[4]) begin
      z = 32'(ua * ub + uc);
    end else begin
      case (inst[3:0])
        4'd0, 4'd1: begin
          us = ua + ub + longint'(cin);
          ss = sa + sb + cin;
          z  = 32'(us);
          cy = (us > 64'hFFFF_FFFF);
          v  = (ss > SMAX) || (ss < SMIN);
        end
        4'd2: begin
          ss = sa - sb;
          z  = a - b;
          cy = (a >= b);
          v  = (ss > SMAX) || (ss < SMIN);
        end
        4'd3:  z = a & b;
        4'd4:  z = a | b;
        4'd5:  z = a ^ b;
        4'd6:  z = ~a;
        4'd7:  z = a;
        4'd8:  z = a << sh;
        4'd9:  z = a >> sh;
        4'd10: z = 32'(sa >>> sh);
        default: z = '0;
      endcase
    end
    return {z[31], (z == 32'd0), cy, v, z};
  endfunction

  // One clock cycle of traffic: drive, score outputs, record acceptance.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [4:0] inst, input logic ci,
                      input logic ordy, output logic acc, output logic rdy);
    logic [35:0] e;
    @(negedge clk);
    ifc.IN_VALID  = v;
    ifc.A         = a;
    ifc.B         = b;
    ifc.C         = c;
    ifc.INST      = inst;
    ifc.CI        = ci;
    ifc.OUT_READY = ordy;
    #1;
    if (prev_stall) begin
      chk("hold_valid", ifc.OUT_VALID, 1);
      chk("hold_z", ifc.Z, prev_z);
      chk("hold_flags", ifc.FLAGS, prev_flags);
    end
    chk("in_ready_rule", ifc.IN_READY, !(ifc.OUT_VALID && !ordy));
    if (ifc.OUT_VALID && ordy) begin
      chk("result_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("result_z", ifc.Z, e[31:0]);
        chk("result_flags", ifc.FLAGS, e[35:32]);
        n_res++;
      end
    end
    rdy = ifc.IN_READY;
    acc = v && ifc.IN_READY;
    if (acc) exp_q.push_back(ref_op(a, b, c, inst, ci));
    prev_stall = ifc.OUT_VALID && !ordy;
    prev_z     = ifc.Z;
    prev_flags = ifc.FLAGS;
    @(posedge clk);
  endtask

  task automatic drain();
    logic acc, rdy;
    for (int k = 0; k < 4 * LAT + 8 && exp_q.size() > 0; k++)
      step(1'b0, '0, '0, '0, 5'd0, 1'b0, 1'b1, acc, rdy);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Single op into an empty pipe; checks exact latency and constant expected result.
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [4:0] inst, input logic ci,
                          input logic [31:0] ez, input logic [3:0] ef);
    @(negedge clk);
    ifc.A = a; ifc.B = b; ifc.C = c; ifc.INST = inst; ifc.CI = ci;
    ifc.IN_VALID  = 1'b1;
    ifc.OUT_READY = 1'b1;
    #1;
    chk({tag, "_in_ready"}, ifc.IN_READY, 1);
    @(posedge clk);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      ifc.IN_VALID = 1'b0;
      #1;
      chk({tag, "_out_valid"}, ifc.OUT_VALID, (k == LAT));
    end
    chk({tag, "_z"}, ifc.Z, ez);
    chk({tag, "_flags"}, ifc.FLAGS, ef);
    $display("op %s A=%h B=%h C=%h INST=%h -> Z=%h FLAGS=%b", tag, a, b, c, inst, ifc.Z, ifc.FLAGS);
    @(posedge clk);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic acc, rdy, have_op, v;
    logic [31:0] ra, rb, rc;
    logic [4:0]  rinst;
    logic        rci;
    int idx, lowcnt, n_acc;

    ifc.IN_VALID = 1'b0; ifc.OUT_READY = 1'b1;
    ifc.A = '0; ifc.B = '0; ifc.C = '0; ifc.INST = '0; ifc.CI = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", ifc.OUT_VALID, 0);
    chk("reset_in_ready", ifc.IN_READY, 1);
    chk("reset_z", ifc.Z, 0);
    chk("reset_flags", ifc.FLAGS, 0);
    rst_n = 1'b1;

    directed("add",      32'd5,          32'd7,          32'd0,       5'd0,  1'b0, 32'd12,         4'b0000);
    directed("add_ovf",  32'h7FFF_FFFF,  32'd1,          32'd0,       5'd0,  1'b0, 32'h8000_0000,  4'b1001);
    directed("sub_eq",   32'd3,          32'd3,          32'd0,       5'd2,  1'b0, 32'd0,          4'b0110);
    directed("adc_wrap", 32'hFFFF_FFFF,  32'd0,          32'd0,       5'd1,  1'b1, 32'd0,          4'b0110);
    directed("madd",     32'd3,          32'd4,          32'd5,       5'd16, 1'b0, 32'd17,         4'b0000);
    directed("madd_wrap",32'h0001_0000,  32'h0001_0000,  32'd1,       5'd23, 1'b0, 32'd1,          4'b0000);
    directed("sra",      32'h8000_0000,  32'd4,          32'd0,       5'd10, 1'b0, 32'hF800_0000,  4'b1000);
    directed("sll_b33",  32'd3,          32'd33,         32'd0,       5'd8,  1'b0, 32'd6,          4'b0000);
    directed("reserved", 32'h1234_5678,  32'h9ABC_DEF0,  32'd0,       5'd12, 1'b0, 32'd0,          4'b0100);

    // Back-to-back ops with a 4-cycle consumer stall mid-stream.
    prev_stall = 1'b0; n_res = 0; lowcnt = 0; idx = 0;
    for (int i = 0; i < 30 && idx < 8; i++) begin
      step(1'b1, 32'(idx * 3 + 1), 32'(idx + 10), 32'(idx), 5'(idx % 11), 1'b1,
           !(i >= 5 && i < 9), acc, rdy);
      if (!rdy) lowcnt++;
      if (acc) idx++;
    end
    drain();
    chk("stall_in_ready_low_cycles", lowcnt, 4);
    chk("stall_results_count", n_res, 8);
    $display("stall phase: accepted=%0d results=%0d in_ready_low=%0d", idx, n_res, lowcnt);

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'(100 + i), 32'd1, 32'd0, 5'd0, 1'b0, 1'b1, acc, rdy);
    @(negedge clk);
    ifc.IN_VALID = 1'b0;
    #1;
    chk("pre_reset_out_valid", ifc.OUT_VALID, 1);
    rst_n = 1'b0;
    #1;
    chk("in_reset_out_valid", ifc.OUT_VALID, 0);
    chk("in_reset_z", ifc.Z, 0);
    chk("in_reset_flags", ifc.FLAGS, 0);
    chk("in_reset_in_ready", ifc.IN_READY, 1);
    exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++)
      step(1'b0, '0, '0, '0, 5'd0, 1'b0, 1'b1, acc, rdy);
    directed("post_reset_add", 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 32'd3, 4'b0000);

    // Randomized traffic with random gaps and backpressure.
    prev_stall = 1'b0; n_res = 0; n_acc = 0; have_op = 1'b0;
    ra = '0; rb = '0; rc = '0; rinst = '0; rci = 1'b0;
    for (int i = 0; i < 3000 && n_acc < 200; i++) begin
      if (!have_op) begin
        v = ($urandom_range(0, 3) != 0);
        if (v) begin
          ra = rand_operand(); rb = rand_operand(); rc = rand_operand();
          rinst = ($urandom_range(0, 4) == 0) ? 5'(16 + $urandom_range(0, 15))
                                              : 5'($urandom_range(0, 15));
          rci = 1'($urandom_range(0, 1));
          have_op = 1'b1;
        end
      end
      step(have_op, ra, rb, rc, rinst, rci, ($urandom_range(0, 3) != 0), acc, rdy);
      if (acc) begin
        n_acc++;
        have_op = 1'b0;
        $display("rand op %0d A=%h B=%h C=%h INST=%h CI=%b", n_acc, ra, rb, rc, rinst, rci);
      end
    end
    drain();
    chk("random_accepted", n_acc, 200);
    chk("random_results", n_res, n_acc);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
